// File: rtl/fifo_pkg.sv
// Shared definitions for both pointer-control halves of the asynchronous FIFO.
// The Gray helpers run at a fixed 32-bit width; callers zero-extend and truncate.
package fifo_pkg;

  localparam int ADDR_SIZE_DEFAULT   = 4;
  localparam int AFULL_LEVEL_DEFAULT = 12;
  localparam int PTR_MAX             = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Zero upper bits stay zero, so a zero-extended Gray value decodes correctly.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO control bundle: producer request, synchronized-in read pointer,
// and the memory write port / status outputs.
interface wptr_full_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
);

  logic                 winc;
  logic [ADDR_SIZE:0]   rptr_gray;
  logic [ADDR_SIZE-1:0] waddr;
  logic                 wclk_en;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wcount;

  modport master (
    output winc, rptr_gray,
    input  waddr, wclk_en, wptr, wfull, walmost_full, wcount
  );

  modport slave (
    input  winc, rptr_gray,
    output waddr, wclk_en, wptr, wfull, walmost_full, wcount
  );

endinterface

// File: rtl/sync_r2w.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock.
// Clock-agnostic so the read side can reuse it with the clocks swapped.
module sync_r2w #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full flags and occupancy for the async FIFO.
// Flags use the twice-synchronized read pointer, so they may lag but never under-report.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = ADDR_SIZE_DEFAULT,
  parameter int AFULL_LEVEL = AFULL_LEVEL_DEFAULT
) (
  input logic             wclk,
  input logic             wrst,
  wptr_full_ctrl_if.slave bus
);

  localparam int PW = ADDR_SIZE + 1;
  // Full when the Gray pointers differ only in their top two bits.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(ADDR_SIZE-1){1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wgraynext;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] count_next;
  logic          full_next;
  logic          afull_next;
  logic          wen;
  logic          wfull_q;
  logic          walmost_full_q;
  logic [PW-1:0] wcount_q;

  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (bus.rptr_gray),
    .q   (rq2)
  );

  assign wen        = bus.winc & ~wfull_q;
  assign wbinnext   = wbin + PW'(wen);
  assign wgraynext  = PW'(bin2gray(PTR_MAX'(wbinnext)));
  assign rbin_sync  = PW'(gray2bin(PTR_MAX'(rq2)));
  assign count_next = wbinnext - rbin_sync;
  assign full_next  = (wgraynext == (rq2 ^ FULL_MASK));
  assign afull_next = (PTR_MAX'(count_next) >= PTR_MAX'(AFULL_LEVEL));

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin           <= '0;
      wgray          <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wcount_q       <= '0;
    end else begin
      wbin           <= wbinnext;
      wgray          <= wgraynext;
      wfull_q        <= full_next;
      walmost_full_q <= afull_next;
      wcount_q       <= count_next;
    end
  end

  assign bus.waddr        = wbin[ADDR_SIZE-1:0];
  assign bus.wclk_en      = wen;
  assign bus.wptr         = wgray;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wcount       = wcount_q;

endmodule
